// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scanner with a frame-coherent snapshot of the digit codes.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [4:0] bcd3,
    input  logic [4:0] bcd2,
    input  logic [4:0] bcd1,
    input  logic [4:0] bcd0,
    input  logic       si,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_TH = CW'(BLANK_CYCLES);

    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'h00:   s = 7'h40;
            5'h01:   s = 7'h79;
            5'h02:   s = 7'h24;
            5'h03:   s = 7'h30;
            5'h04:   s = 7'h19;
            5'h05:   s = 7'h12;
            5'h06:   s = 7'h02;
            5'h07:   s = 7'h78;
            5'h08:   s = 7'h00;
            5'h09:   s = 7'h10;
            5'h1F:   s = 7'h77;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // A digit counts as "leading" filler when it is zero or a blank code.
    function automatic logic is_filler(input logic [4:0] code);
        return (code == 5'h00) || ((code >= 5'h0A) && (code <= 5'h1E));
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [19:0]   snap_dig_q, snap_dig_d;
    logic          snap_si_q, snap_si_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [4:0] code_sel;
    logic [3:0] suppress;
    logic       frame_start;

    always_comb begin
        frame_start = (cnt_q == '0) && (idx_q == 2'd0);
        cnt_d       = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        idx_d       = (cnt_q == CNT_MAX) ? idx_q + 2'd1 : idx_q;
        snap_dig_d  = frame_start ? {bcd3, bcd2, bcd1, bcd0} : snap_dig_q;
        snap_si_d   = frame_start ? si : snap_si_q;

        code_sel = snap_dig_d[idx_d*5 +: 5];

        suppress = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        suppress[3] = (snap_dig_d[19:15] == 5'h00);
        suppress[2] = (snap_dig_d[14:10] == 5'h00) && is_filler(snap_dig_d[19:15]);
        suppress[1] = (snap_dig_d[9:5] == 5'h00) && is_filler(snap_dig_d[19:15])
                      && is_filler(snap_dig_d[14:10]);
`else
        suppress[3] = 1'b0 & is_filler(snap_dig_d[19:15]);
`endif

        // Outputs are computed from the next state so they line up with counter/index.
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (cnt_d >= BLANK_TH) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = suppress[idx_d] ? 7'h7F : decode(code_sel);
            dp_d  = ~((idx_d == 2'd3) && snap_si_d);
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            snap_dig_q <= '0;
            snap_si_q  <= 1'b0;
            an_q       <= 4'hF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_dig_q <= snap_dig_d;
            snap_si_q  <= snap_si_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
